// File: rtl/stack_pkg.sv
// Shared definitions for the stack calculator front-end and controller.
package stack_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BTN_W  = 4;

    // Stack command opcodes
    typedef enum logic [OP_W-1:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_TOP  = 3'd4,
        OP_CLR  = 3'd5,
        OP_DEC  = 3'd6,
        OP_INC  = 3'd7
    } op_e;

    // Mode select encodings taken from {btn3, btn2}
    typedef enum logic [1:0] {
        MODE_STACK = 2'b00,
        MODE_ARITH = 2'b01,
        MODE_VIEW  = 2'b10,
        MODE_STEP  = 2'b11
    } mode_e;

    // Command payload handed to the stack controller
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // Each mode owns an opcode pair; btn1 selects the odd member
    function automatic logic [OP_W-1:0] decode_op(input logic [1:0] mode, input logic sel_btn1);
        return {mode, sel_btn1};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit synchroniser plus debounce counter for a raw push-button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept the synced level after a full run of disagreeing edges; any agreement restarts the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else if (cnt < CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stack_input_decoder.sv
// Turns debounced button presses into single buffered stack commands.
module stack_input_decoder
    import stack_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BTN_W-1:0]  btns,
    input  logic [DATA_W-1:0] swtchs,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] cmd_data,
    output logic              drop_flag
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    buf_state_e        state;
    logic [BTN_W-1:0]  btn_db;
    logic [BTN_W-1:0]  btn_db_q;
    logic [DATA_W-1:0] sw_sync1;
    logic [DATA_W-1:0] sw_sync2;

    logic              pulse0_c;
    logic              pulse1_c;
    logic              trig_c;
    logic              handshake_c;
    logic              drop_c;
    logic              clr_xfer_c;
    logic [OP_W-1:0]   op_c;

    for (genvar i = 0; i < int'(BTN_W); i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btns[i]),
            .level(btn_db[i])
        );
    end

    // Switch synchroniser and previous debounced levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
            btn_db_q <= '0;
        end else begin
            sw_sync1 <= swtchs;
            sw_sync2 <= sw_sync1;
            btn_db_q <= btn_db;
        end
    end

    // Press detection, opcode decode and drop conditions; btn0 wins a tie
    always_comb begin
        pulse0_c    = btn_db[0] & ~btn_db_q[0];
        pulse1_c    = btn_db[1] & ~btn_db_q[1];
        trig_c      = pulse0_c | pulse1_c;
        op_c        = decode_op(btn_db[3:2], ~pulse0_c);
        handshake_c = cmd_valid & cmd_ready;
        drop_c      = (pulse0_c & pulse1_c) | (trig_c & cmd_valid & ~cmd_ready);
        clr_xfer_c  = handshake_c & (cmd_op == OP_CLR);
    end

    // Single-entry command buffer; payload only changes on a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_data  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (trig_c) begin
                        state     <= FULL;
                        cmd_valid <= 1'b1;
                        cmd_op    <= op_c;
                        cmd_data  <= sw_sync2;
                    end
                end
                FULL: begin
                    if (handshake_c) begin
                        if (trig_c) begin
                            cmd_op   <= op_c;
                            cmd_data <= sw_sync2;
                        end else begin
                            state     <= EMPTY;
                            cmd_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky lost-press flag, cleared by a CLR transfer unless a drop coincides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_flag <= 1'b0;
        end else if (drop_c) begin
            drop_flag <= 1'b1;
        end else if (clr_xfer_c) begin
            drop_flag <= 1'b0;
        end
    end

endmodule
